// File: rtl/hc595_chain_driver_if.sv
// Frame load handshake between a producer and the 74HC595 chain driver.
interface hc595_chain_driver_if #(
    parameter int DATA_WIDTH = 14
);
    logic                  load_valid;
    logic                  load_ready;
    logic [DATA_WIDTH-1:0] load_data;

    modport master (output load_valid, output load_data, input load_ready);
    modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/hc595_chain_driver.sv
// Handshaked frame driver for a cascade of 74HC595 shift registers,
// with a PWM brightness signal on the active-low output enable.
module hc595_chain_driver #(
    parameter int DATA_WIDTH   = 14,
    parameter int CLK_DIV      = 4,
    parameter bit LSB_FIRST    = 1'b0,
    parameter int BRIGHT_WIDTH = 4
) (
    input  logic                    system_clock,
    input  logic                    system_reset_n,
    hc595_chain_driver_if.slave     load,
    input  logic [BRIGHT_WIDTH-1:0] brightness,
    output logic                    ds,
    output logic                    shcp,
    output logic                    stcp,
    output logic                    oe,
    output logic                    busy,
    output logic                    frame_done
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV / 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t                  state, state_d;
    logic [IW-1:0]           idx, idx_d;
    logic [PW-1:0]           phase, phase_d;
    logic [DATA_WIDTH-1:0]   shreg, shreg_d, ordered;
    logic [BRIGHT_WIDTH-1:0] pwm_cnt, pwm_d;
    logic                    latched_once, latched_d;
    logic                    ds_d, shcp_d, stcp_d, oe_d, busy_d, ready_d, done_d;

    // The shift register always shifts MSB-out, so LSB-first frames are reversed on capture.
    always_comb begin
        ordered = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            ordered[i] = LSB_FIRST ? load.load_data[DATA_WIDTH-1-i] : load.load_data[i];
        end
    end

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        phase_d   = phase;
        shreg_d   = shreg;
        ds_d      = ds;
        busy_d    = busy;
        ready_d   = load.load_ready;
        done_d    = 1'b0;
        latched_d = latched_once;
        case (state)
            IDLE: begin
                if (load.load_valid && load.load_ready) begin
                    shreg_d = ordered;
                    ds_d    = ordered[DATA_WIDTH-1];
                    idx_d   = '0;
                    phase_d = '0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (phase == PH_LAST) begin
                    phase_d = '0;
                    if (idx == IDX_LAST) begin
                        state_d = LATCH;
                    end else begin
                        idx_d   = idx + 1'b1;
                        shreg_d = {shreg[DATA_WIDTH-2:0], 1'b0};
                        ds_d    = shreg[DATA_WIDTH-2];
                    end
                end else begin
                    phase_d = phase + 1'b1;
                end
            end
            LATCH: begin
                if (phase == PH_LAST) begin
                    phase_d   = '0;
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    latched_d = 1'b1;
                    busy_d    = 1'b0;
                    ready_d   = 1'b1;
                end else begin
                    phase_d = phase + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from next-state values so the registered pins line up with phase.
        shcp_d = (state_d == SHIFT) && (phase_d >= PH_HALF);
        stcp_d = (state_d == LATCH) && (phase_d >= PH_HALF);
        pwm_d  = pwm_cnt + 1'b1;
        oe_d   = !(latched_d && ((pwm_d < brightness) || (&brightness)));
    end

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state           <= IDLE;
            idx             <= '0;
            phase           <= '0;
            shreg           <= '0;
            pwm_cnt         <= '0;
            latched_once    <= 1'b0;
            ds              <= 1'b0;
            shcp            <= 1'b0;
            stcp            <= 1'b0;
            oe              <= 1'b1;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            load.load_ready <= 1'b1;
        end else begin
            state           <= state_d;
            idx             <= idx_d;
            phase           <= phase_d;
            shreg           <= shreg_d;
            pwm_cnt         <= pwm_d;
            latched_once    <= latched_d;
            ds              <= ds_d;
            shcp            <= shcp_d;
            stcp            <= stcp_d;
            oe              <= oe_d;
            busy            <= busy_d;
            frame_done      <= done_d;
            load.load_ready <= ready_d;
        end
    end
endmodule

// File: tb/tb_hc595_chain_driver.sv
// Directed bench for hc595_chain_driver: MSB-first and LSB-first instances share stimulus.
module tb_hc595_chain_driver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [13:0] data = '0;
    logic [3:0]  bright = 4'd8;

    logic ds0, shcp0, stcp0, oe0, busy0, done0;
    logic ds1, shcp1, stcp1, oe1, busy1, done1;

    int vectors = 0;
    int miscompares = 0;

    hc595_chain_driver_if #(.DATA_WIDTH(14)) bus0 ();
    hc595_chain_driver_if #(.DATA_WIDTH(14)) bus1 ();

    assign bus0.load_valid = valid;
    assign bus0.load_data  = data;
    assign bus1.load_valid = valid;
    assign bus1.load_data  = data;

    hc595_chain_driver #(.DATA_WIDTH(14), .CLK_DIV(4), .LSB_FIRST(1'b0), .BRIGHT_WIDTH(4)) dut0 (
        .system_clock(clk), .system_reset_n(rst_n), .load(bus0.slave), .brightness(bright),
        .ds(ds0), .shcp(shcp0), .stcp(stcp0), .oe(oe0), .busy(busy0), .frame_done(done0)
    );

    hc595_chain_driver #(.DATA_WIDTH(14), .CLK_DIV(4), .LSB_FIRST(1'b1), .BRIGHT_WIDTH(4)) dut1 (
        .system_clock(clk), .system_reset_n(rst_n), .load(bus1.slave), .brightness(bright),
        .ds(ds1), .shcp(shcp1), .stcp(stcp1), .oe(oe1), .busy(busy1), .frame_done(done1)
    );

    always #5 clk = ~clk;

    // Edge monitor sampled on the falling clock edge.
    logic [63:0] cap0 = '0, cap1 = '0;
    int rises0 = 0, rises1 = 0, stcp_rises = 0, stcp_high = 0, busy_cnt = 0, oe_low = 0;
    logic shcp0_p = 1'b0, shcp1_p = 1'b0, stcp0_p = 1'b0;

    always @(negedge clk) begin
        if (shcp0 && !shcp0_p) begin cap0 = {cap0[62:0], ds0}; rises0++; end
        if (shcp1 && !shcp1_p) begin cap1 = {cap1[62:0], ds1}; rises1++; end
        if (stcp0 && !stcp0_p) stcp_rises++;
        if (stcp0) stcp_high++;
        if (busy0) busy_cnt++;
        if (!oe0) oe_low++;
        shcp0_p = shcp0;
        shcp1_p = shcp1;
        stcp0_p = stcp0;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        cap0 = '0; cap1 = '0;
        rises0 = 0; rises1 = 0; stcp_rises = 0; stcp_high = 0; busy_cnt = 0; oe_low = 0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int start, output int n);
        n = start;
        do begin
            tick();
            n++;
        end while (!done0 && n < 400);
    endtask

    // One isolated frame with full shape checks on both instances.
    task automatic run_frame(input string tag, input logic [13:0] d,
                             input logic [13:0] exp0, input logic [13:0] exp1);
        int n;
        clear_mon();
        valid = 1'b1;
        data  = d;
        tick();
        valid = 1'b0;
        check({tag, "_busy_after_accept"}, {62'd0, busy0, bus0.load_ready}, 64'h2);
        wait_done(1, n);
        check({tag, "_latency"}, 64'(n - 1), 64'd60);
        check({tag, "_ready_at_done"}, {63'd0, bus0.load_ready}, 64'h1);
        check({tag, "_bits_msb"}, {50'd0, cap0[13:0]}, {50'd0, exp0});
        check({tag, "_bits_lsb"}, {50'd0, cap1[13:0]}, {50'd0, exp1});
        check({tag, "_shcp_rises"}, 64'(rises0), 64'd14);
        check({tag, "_stcp_rises"}, 64'(stcp_rises), 64'd1);
        check({tag, "_stcp_high"}, 64'(stcp_high), 64'd2);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd60);
    endtask

    initial begin
        int n;

        tick();
        check("in_reset_outputs", {57'd0, ds0, shcp0, stcp0, oe0, bus0.load_ready, busy0, done0},
              64'b0001100);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_outputs", {57'd0, ds0, shcp0, stcp0, oe0, bus0.load_ready, busy0, done0},
              64'b0001100);
        clear_mon();
        repeat (100) tick();
        check("oe_blank_before_frame", 64'(oe_low), 64'd0);

        bright = 4'd15;
        run_frame("f2A5C", 14'h2A5C, 14'h2A5C, 14'h0E95);
        clear_mon();
        repeat (32) tick();
        check("oe_full_on", 64'(oe_low), 64'd32);

        // Back-to-back with held valid and data changes while busy.
        clear_mon();
        valid = 1'b1;
        data  = 14'h0001;
        tick();
        n = 1;
        do begin
            tick();
            n++;
            if (n == 10) data = 14'h1555;
            if (n == 30) data = 14'h3FFF;
        end while (!done0 && n < 400);
        check("b2b_first_latency", 64'(n - 1), 64'd60);
        check("b2b_ready_at_done", {63'd0, bus0.load_ready}, 64'h1);
        check("b2b_first_bits", {50'd0, cap0[13:0]}, 64'h0001);
        tick();
        valid = 1'b0;
        check("b2b_second_accepted", {62'd0, busy0, bus0.load_ready}, 64'h2);
        wait_done(1, n);
        check("b2b_second_latency", 64'(n - 1), 64'd60);
        check("b2b_both_frames", {36'd0, cap0[27:0]}, 64'h0007FFF);
        check("b2b_shcp_rises", 64'(rises0), 64'd28);
        check("b2b_stcp_rises", 64'(stcp_rises), 64'd2);

        bright = 4'd0;
        tick(); tick();
        clear_mon();
        repeat (16) tick();
        check("pwm_b0", 64'(oe_low), 64'd0);
        bright = 4'd8;
        tick(); tick();
        clear_mon();
        repeat (16) tick();
        check("pwm_b8", 64'(oe_low), 64'd8);
        bright = 4'd15;
        tick(); tick();
        clear_mon();
        repeat (16) tick();
        check("pwm_b15", 64'(oe_low), 64'd16);

        // Reset while bit 5 is on ds.
        clear_mon();
        valid = 1'b1;
        data  = 14'h2A5C;
        tick();
        valid = 1'b0;
        n = 0;
        while (rises0 < 5 && n < 200) begin
            tick();
            n++;
        end
        check("reached_bit5", 64'(rises0), 64'd5);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs",
              {57'd0, ds0, shcp0, stcp0, oe0, bus0.load_ready, busy0, done0}, 64'b0001100);
        repeat (3) tick();
        check("midframe_no_latch", 64'(stcp_rises), 64'd0);
        rst_n = 1'b1;
        clear_mon();
        repeat (20) tick();
        check("oe_blank_after_reset", 64'(oe_low), 64'd0);
        run_frame("after_reset", 14'h2A5C, 14'h2A5C, 14'h0E95);
        clear_mon();
        repeat (16) tick();
        check("oe_on_after_relatch", 64'(oe_low), 64'd16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
